tinytester_capture: RTL and testbench

//  Receive-side companion to the tinytester pad driver: samples padin_i once per drive phase (P0..P3),

---
 rtl/tinytester_pkg.sv | 41 ++++
 rtl/tinytester_phase_cmp.sv | 16 +
 rtl/tinytester_capture.sv | 189 ++++++++++++++++++
 tb/tb_tinytester_capture.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinytester_pkg.sv
// Shared definitions for the tinytester capture block: sequencer
// one-hot states, control/status bit indices and a phase decoder.
package tinytester_pkg;

  typedef enum logic [6:0] {
    S_CAP0  = 7'h01,
    S_CAP1  = 7'h02,
    S_CAP2  = 7'h04,
    S_CAP3  = 7'h08,
    S_CHECK = 7'h10,
    S_WAIT  = 7'h20,
    S_IDLE  = 7'h40
  } seq_state_e;

  localparam int CTL_START = 0;
  localparam int CTL_CLR   = 1;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_FAIL      = 2;
  localparam int ST_PFAIL_LSB = 4;

  localparam int SETTLE_W = 8;

  // {is_capture_state, phase_index}
  function automatic logic [2:0] cap_phase(
    input seq_state_e s
  );
    logic [2:0] r;
    r = 3'b000;
    unique case (s)
      S_CAP0:  r = 3'b100;
      S_CAP1:  r = 3'b101;
      S_CAP2:  r = 3'b110;
      S_CAP3:  r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tinytester_phase_cmp.sv
// Masked compare of one pad sample against its expected value.
// Ports: sample_i/expect_i/mask_i in, mismatch_o vector and fail_o out.
module tinytester_phase_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] expect_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] mismatch_o,
  output logic             fail_o
);

  assign mismatch_o = (sample_i ^ expect_i) & mask_i;
  assign fail_o     = |mismatch_o;

endmodule

// File: rtl/tinytester_capture.sv
// Receive-side tester: samples padin_i once per drive phase P0..P3,
// checks against masked per-phase expectations, reports sticky pin
// mismatches, per-phase fail flags and run status.
// Ports: clk, rst (sync, active high), control_i [0]=start [1]=clear,
//   expect_p0_i..p3_i, mask_i, padin_i in; capture_p0_o..p3_o,
//   mismatch_o, status_o, err_count_o, sequencer_state out.
// Macro TINYTESTER_ERRCNT_EN enables the failed-run counter;
// without it err_count_o is tied to zero.
module tinytester_capture
  import tinytester_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      control_i,
  input  logic [WIDTH-1:0] expect_p0_i,
  input  logic [WIDTH-1:0] expect_p1_i,
  input  logic [WIDTH-1:0] expect_p2_i,
  input  logic [WIDTH-1:0] expect_p3_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] padin_i,
  output logic [WIDTH-1:0] capture_p0_o,
  output logic [WIDTH-1:0] capture_p1_o,
  output logic [WIDTH-1:0] capture_p2_o,
  output logic [WIDTH-1:0] capture_p3_o,
  output logic [WIDTH-1:0] mismatch_o,
  output logic [31:0]      status_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [6:0]       sequencer_state
);

  localparam logic [SETTLE_W-1:0] SETTLE_RLD =
    SETTLE_W'(SETTLE_CYCLES);

  seq_state_e          state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    cap_q [4];
  logic [WIDTH-1:0]    cap_d [4];
  logic [WIDTH-1:0]    mis_q, mis_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [3:0]          pfail_q, pfail_d;

  logic             start;
  logic             clr;
  logic [2:0]       cph;
  logic [1:0]       ph;
  logic             is_cap;
  logic [WIDTH-1:0] exp_sel;
  logic [WIDTH-1:0] cmp_mis;
  logic             cmp_fail;
  logic             unused_ctl;

  assign start      = control_i[CTL_START];
  assign clr        = control_i[CTL_CLR];
  assign unused_ctl = ^control_i[31:2];

  assign cph    = cap_phase(state_q);
  assign is_cap = cph[2];
  assign ph     = cph[1:0];

  always_comb begin
    exp_sel = expect_p0_i;
    unique case (ph)
      2'd0: exp_sel = expect_p0_i;
      2'd1: exp_sel = expect_p1_i;
      2'd2: exp_sel = expect_p2_i;
      2'd3: exp_sel = expect_p3_i;
    endcase
  end

  tinytester_phase_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .sample_i  (padin_i),
    .expect_i  (exp_sel),
    .mask_i    (mask_i),
    .mismatch_o(cmp_mis),
    .fail_o    (cmp_fail)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    mis_d   = mis_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    pfail_d = pfail_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAP0;
          cnt_d   = SETTLE_RLD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          pfail_d = 4'b0;
        end
      end
      S_CAP0, S_CAP1, S_CAP2, S_CAP3: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cap_d[ph]   = padin_i;
          pfail_d[ph] = cmp_fail;
          mis_d       = mis_q | cmp_mis;
          cnt_d       = SETTLE_RLD;
          // one-hot shift walks CAP0..CAP3 then CHECK
          state_d = seq_state_e'({state_q[5:0], 1'b0});
        end
      end
      S_CHECK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        fail_d  = |pfail_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) mis_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) cap_q[i] <= '0;
      mis_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      pfail_q <= 4'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      pfail_q <= pfail_d;
    end
  end

`ifdef TINYTESTER_ERRCNT_EN
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == S_CHECK && |pfail_q && err_q != '1)
      err_d = err_q + 1'b1;
    if (clr) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = '0;
`endif

  always_comb begin
    status_o = 32'b0;
    status_o[ST_BUSY] = busy_q;
    status_o[ST_DONE] = done_q;
    status_o[ST_FAIL] = fail_q;
    status_o[ST_PFAIL_LSB +: 4] = pfail_q;
  end

  assign capture_p0_o    = cap_q[0];
  assign capture_p1_o    = cap_q[1];
  assign capture_p2_o    = cap_q[2];
  assign capture_p3_o    = cap_q[3];
  assign mismatch_o      = mis_q;
  assign sequencer_state = state_q;

endmodule

// File: tb/tb_tinytester_capture.sv
// Randomised bench for tinytester_capture: two instances
// (settle 0 and settle 3) checked against a run-level model.
module tb_tinytester_capture;

  localparam int CW = 8;
`ifdef TINYTESTER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctl [2];
  logic [31:0] exp_v [4];
  logic [31:0] mask_v;
  logic [31:0] padin;

  logic [31:0]   cap [2][4];
  logic [31:0]   mis [2];
  logic [31:0]   st [2];
  logic [CW-1:0] ec [2];
  logic [6:0]    sq [2];

  logic [31:0]   m_mis [2];
  logic [CW-1:0] m_err [2];
  logic [31:0]   m_cap [2][4];
  logic [3:0]    m_pf [2];
  logic          m_busy [2];
  logic          m_done [2];
  logic          m_fail [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tinytester_capture #(
    .WIDTH(32), .SETTLE_CYCLES(0), .CNT_W(CW)
  ) dut0 (
    .clk(clk), .rst(rst), .control_i(ctl[0]),
    .expect_p0_i(exp_v[0]), .expect_p1_i(exp_v[1]),
    .expect_p2_i(exp_v[2]), .expect_p3_i(exp_v[3]),
    .mask_i(mask_v), .padin_i(padin),
    .capture_p0_o(cap[0][0]), .capture_p1_o(cap[0][1]),
    .capture_p2_o(cap[0][2]), .capture_p3_o(cap[0][3]),
    .mismatch_o(mis[0]), .status_o(st[0]),
    .err_count_o(ec[0]), .sequencer_state(sq[0])
  );

  tinytester_capture #(
    .WIDTH(32), .SETTLE_CYCLES(3), .CNT_W(CW)
  ) dut3 (
    .clk(clk), .rst(rst), .control_i(ctl[1]),
    .expect_p0_i(exp_v[0]), .expect_p1_i(exp_v[1]),
    .expect_p2_i(exp_v[2]), .expect_p3_i(exp_v[3]),
    .mask_i(mask_v), .padin_i(padin),
    .capture_p0_o(cap[1][0]), .capture_p1_o(cap[1][1]),
    .capture_p2_o(cap[1][2]), .capture_p3_o(cap[1][3]),
    .mismatch_o(mis[1]), .status_o(st[1]),
    .err_count_o(ec[1]), .sequencer_state(sq[1])
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mis[d] = '0; m_err[d] = '0; m_pf[d] = '0;
      m_busy[d] = 0; m_done[d] = 0; m_fail[d] = 0;
      for (int i = 0; i < 4; i++) m_cap[d][i] = '0;
    end
  endtask

  // One complete run on instance d with settle s; samp[n] is the
  // pad value present at the phase-n sampling edge.
  task automatic do_run(input int d, input int s,
                        input logic [31:0] samp [4],
                        input bit clr, input string tag);
    logic [31:0]   est;
    logic [6:0]    sst;
    logic [CW-1:0] eerr;
    logic [127:0]  gcap, ecap;
    int per, n;
    per = s + 1;
    @(negedge clk);
    ctl[d] = {30'd0, clr, 1'b1};
    padin = $urandom;
    @(posedge clk);
    m_busy[d] = 1; m_done[d] = 0; m_fail[d] = 0; m_pf[d] = '0;
    if (clr) begin m_mis[d] = '0; m_err[d] = '0; end
    #1;
    n_chk++;
    if (sq[d] !== 7'h01) begin
      n_fail++;
      $display("FAIL %s start_state: got %h want 01", tag, sq[d]);
    end
    for (int e = 1; e <= 4 * per; e++) begin
      @(negedge clk);
      if (e % per == 0) padin = samp[e / per - 1];
      else padin = $urandom;
      @(posedge clk);
      if (e % per == 0) begin
        n = e / per - 1;
        m_cap[d][n] = padin;
        m_mis[d] |= (padin ^ exp_v[n]) & mask_v;
        m_pf[d][n] = |((padin ^ exp_v[n]) & mask_v);
      end
      if (clr) m_mis[d] = '0;
      #1;
      sst = (e == 4 * per) ? 7'h10 : 7'(1 << (e / per));
      est = {24'd0, m_pf[d], 1'b0, m_fail[d], m_done[d], m_busy[d]};
      ecap = {m_cap[d][3], m_cap[d][2], m_cap[d][1], m_cap[d][0]};
      gcap = {cap[d][3], cap[d][2], cap[d][1], cap[d][0]};
      n_chk++;
      if (sq[d] !== sst) begin
        n_fail++;
        $display("FAIL %s state e%0d: got %h want %h", tag, e, sq[d], sst);
      end
      n_chk++;
      if (st[d] !== est) begin
        n_fail++;
        $display("FAIL %s status e%0d: got %h want %h", tag, e, st[d], est);
      end
      n_chk++;
      if (mis[d] !== m_mis[d]) begin
        n_fail++;
        $display("FAIL %s mismatch e%0d: got %h want %h",
                 tag, e, mis[d], m_mis[d]);
      end
      n_chk++;
      if (gcap !== ecap) begin
        n_fail++;
        $display("FAIL %s captures e%0d: got %h want %h", tag, e, gcap, ecap);
      end
    end
    @(negedge clk);
    padin = $urandom;
    @(posedge clk);
    m_busy[d] = 0; m_done[d] = 1; m_fail[d] = |m_pf[d];
    if (m_fail[d] && m_err[d] != '1) m_err[d] = m_err[d] + 1'b1;
    if (clr) begin m_err[d] = '0; m_mis[d] = '0; end
    #1;
    est = {24'd0, m_pf[d], 1'b0, m_fail[d], m_done[d], m_busy[d]};
    eerr = ERR_EN ? m_err[d] : '0;
    n_chk++;
    if (sq[d] !== 7'h20) begin
      n_fail++;
      $display("FAIL %s check_state: got %h want 20", tag, sq[d]);
    end
    n_chk++;
    if (st[d] !== est) begin
      n_fail++;
      $display("FAIL %s done_status: got %h want %h", tag, st[d], est);
    end
    n_chk++;
    if (ec[d] !== eerr) begin
      n_fail++;
      $display("FAIL %s err_count: got %h want %h", tag, ec[d], eerr);
    end
    n_chk++;
    if (mis[d] !== m_mis[d]) begin
      n_fail++;
      $display("FAIL %s final_mismatch: got %h want %h",
               tag, mis[d], m_mis[d]);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (sq[d] !== 7'h20) begin
      n_fail++;
      $display("FAIL %s hold_wait: got %h want 20", tag, sq[d]);
    end
    @(negedge clk);
    ctl[d] = '0;
    @(posedge clk);
    #1;
    n_chk++;
    if (sq[d] !== 7'h40 || st[d] !== est) begin
      n_fail++;
      $display("FAIL %s back_idle: got %h/%h want 40/%h",
               tag, sq[d], st[d], est);
    end
  endtask

  task automatic do_clear(input int d, input string tag);
    @(negedge clk);
    ctl[d] = 32'h2;
    @(posedge clk);
    m_mis[d] = '0; m_err[d] = '0;
    #1;
    n_chk++;
    if (mis[d] !== 32'h0 || ec[d] !== '0) begin
      n_fail++;
      $display("FAIL %s clear: got %h/%h want 0/0", tag, mis[d], ec[d]);
    end
    @(negedge clk);
    ctl[d] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctl[0] = '0; ctl[1] = '0;
    padin = '0; mask_v = '1;
    for (int i = 0; i < 4; i++) exp_v[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (sq[d] !== 7'h40 || st[d] !== 32'h0 || mis[d] !== 32'h0 ||
          ec[d] !== '0 || cap[d][0] !== 32'h0 || cap[d][3] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset d%0d: got %h/%h/%h/%h want 40/0/0/0",
                 d, sq[d], st[d], mis[d], ec[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass();
    logic [31:0] sp [4];
    for (int i = 0; i < 4; i++) begin
      exp_v[i] = 32'hA5A5_A5A5;
      sp[i] = 32'hA5A5_A5A5;
    end
    mask_v = '1;
    do_run(0, 0, sp, 1'b0, "pass");
  endtask

  task automatic test_phase_fail();
    logic [31:0] sp [4];
    for (int i = 0; i < 4; i++) sp[i] = 32'hA5A5_A5A5;
    sp[2] = 32'hA5A5_A5A4;
    do_run(0, 0, sp, 1'b0, "p2fail");
  endtask

  task automatic test_mask();
    logic [31:0] sp [4];
    do_clear(0, "mask_pre");
    for (int i = 0; i < 4; i++) sp[i] = 32'hA5A5_A5A5;
    sp[2] = 32'hA5A5_A5A4;
    mask_v = 32'hFFFF_FFFE;
    do_run(0, 0, sp, 1'b0, "masked");
  endtask

  task automatic test_settle();
    logic [31:0] sp [4];
    for (int r = 0; r < 3; r++) begin
      mask_v = $urandom;
      for (int i = 0; i < 4; i++) begin
        exp_v[i] = $urandom;
        sp[i] = exp_v[i] ^ (($urandom % 2 == 0) ? 32'h0 : $urandom);
      end
      do_run(1, 3, sp, 1'b0, "settle3");
    end
  endtask

  task automatic test_random();
    logic [31:0] sp [4];
    for (int r = 0; r < 12; r++) begin
      mask_v = ($urandom % 2 == 0) ? 32'hFFFF_FFFF : $urandom;
      for (int i = 0; i < 4; i++) begin
        exp_v[i] = $urandom;
        sp[i] = exp_v[i];
        if ($urandom % 3 == 0) sp[i] ^= 32'(1) << ($urandom % 32);
      end
      do_run(0, 0, sp, 1'b0, "random");
    end
  endtask

  task automatic test_saturate();
    logic [31:0] sp [4];
    mask_v = '1;
    for (int i = 0; i < 4; i++) begin
      exp_v[i] = 32'hA5A5_A5A5;
      sp[i] = 32'hA5A5_A5A5;
    end
    sp[1] = 32'h5A5A_A5A5;
    for (int r = 0; r < (1 << CW) + 2; r++)
      do_run(0, 0, sp, 1'b0, "saturate");
    do_clear(0, "sat_clear");
    do_run(0, 0, sp, 1'b1, "clr_wins");
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    ctl[0] = 32'h1;
    padin = $urandom;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (sq[0] !== 7'h02) begin
      n_fail++;
      $display("FAIL midrun_cap1: got %h want 02", sq[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    n_chk++;
    if (sq[0] !== 7'h40 || st[0] !== 32'h0 || mis[0] !== 32'h0 ||
        ec[0] !== '0 || cap[0][0] !== 32'h0 || cap[0][1] !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h/%h/%h/%h want 40/0/0/0",
               sq[0], st[0], mis[0], cap[0][0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (sq[0] !== 7'h01 || st[0] !== 32'h1) begin
      n_fail++;
      $display("FAIL restart: got %h/%h want 01/1", sq[0], st[0]);
    end
    repeat (5) @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++;
      if (sq[0] !== 7'h20 || st[0][1:0] !== 2'b10) begin
        n_fail++;
        $display("FAIL no_retrigger c%0d: got %h/%h want 20/done",
                 c, sq[0], st[0]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    ctl[0] = '0;
    @(posedge clk);
    @(negedge clk);
    ctl[0] = 32'h1;
    @(posedge clk);
    #1;
    n_chk++;
    if (sq[0] !== 7'h01) begin
      n_fail++;
      $display("FAIL rearm: got %h want 01", sq[0]);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_phase_fail();
    test_mask();
    test_settle();
    test_random();
    test_saturate();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
